// File: rtl/draw_pkg.sv
// Shared definitions for the draw command path:
// superpixel geometry, colour width and scheduler states.
package draw_pkg;

    localparam int SPIXEL_X_WIDTH = 6;
    localparam int SPIXEL_Y_WIDTH = 6;
    localparam int SPIXEL_X_MAX   = 63;
    localparam int SPIXEL_Y_MAX   = 47;
    localparam int COLOR_ID_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first requester at or after ptr,
// wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    // Walk offsets from farthest to nearest so the nearest wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = |req;
        j     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % N;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/draw_cmd_scheduler.sv
// Arbitrates client rectangle commands and runs them one at a
// time through the rectangle drawer with a completion watchdog.
module draw_cmd_scheduler #(
    parameter int N_REQ          = 4,
    parameter int SPIXEL_X_WIDTH = draw_pkg::SPIXEL_X_WIDTH,
    parameter int SPIXEL_Y_WIDTH = draw_pkg::SPIXEL_Y_WIDTH,
    parameter int SPIXEL_X_MAX   = draw_pkg::SPIXEL_X_MAX,
    parameter int SPIXEL_Y_MAX   = draw_pkg::SPIXEL_Y_MAX,
    parameter int COLOR_ID_WIDTH = draw_pkg::COLOR_ID_WIDTH,
    parameter int TMO_CYCLES     = 400000,
    parameter int TMO_WIDTH      = 20
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_REQ-1:0]                    req,
    input  logic [N_REQ*SPIXEL_X_WIDTH-1:0]     req_x0,
    input  logic [N_REQ*SPIXEL_X_WIDTH-1:0]     req_x1,
    input  logic [N_REQ*SPIXEL_Y_WIDTH-1:0]     req_y0,
    input  logic [N_REQ*SPIXEL_Y_WIDTH-1:0]     req_y1,
    input  logic [N_REQ*COLOR_ID_WIDTH-1:0]     req_color,
    output logic [N_REQ-1:0]                    gnt,
    output logic [N_REQ-1:0]                    cmd_done,
    output logic                                cmd_err,
    output logic                                busy,
    output logic [SPIXEL_X_WIDTH-1:0]           dx0,
    output logic [SPIXEL_X_WIDTH-1:0]           dx1,
    output logic [SPIXEL_Y_WIDTH-1:0]           dy0,
    output logic [SPIXEL_Y_WIDTH-1:0]           dy1,
    output logic [COLOR_ID_WIDTH-1:0]           dcolor,
    output logic                                dvld,
    input  logic                                ddone
);

    import draw_pkg::*;

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int XW = SPIXEL_X_WIDTH;
    localparam int YW = SPIXEL_Y_WIDTH;
    localparam int CW = COLOR_ID_WIDTH;

    state_t state, next_state;

    logic [IW-1:0]        ptr, win, ptr_next;
    logic [N_REQ-1:0]     win_oh;
    logic [TMO_WIDTH-1:0] cnt;
    logic                 err_flag, tmo;

    logic [N_REQ-1:0] arb_grant;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;

    logic [XW-1:0] cx0, cx1;
    logic [YW-1:0] cy0, cy1;
    logic [CW-1:0] sel_color;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Winner's fields, clipped to the visible grid before ordering.
    always_comb begin
        cx0 = req_x0[int'(arb_idx) * XW +: XW];
        cx1 = req_x1[int'(arb_idx) * XW +: XW];
        cy0 = req_y0[int'(arb_idx) * YW +: YW];
        cy1 = req_y1[int'(arb_idx) * YW +: YW];
        sel_color = req_color[int'(arb_idx) * CW +: CW];
        if (cx0 > XW'(SPIXEL_X_MAX)) cx0 = XW'(SPIXEL_X_MAX);
        if (cx1 > XW'(SPIXEL_X_MAX)) cx1 = XW'(SPIXEL_X_MAX);
        if (cy0 > YW'(SPIXEL_Y_MAX)) cy0 = YW'(SPIXEL_Y_MAX);
        if (cy1 > YW'(SPIXEL_Y_MAX)) cy1 = YW'(SPIXEL_Y_MAX);
    end

    assign tmo      = (cnt == TMO_WIDTH'(TMO_CYCLES - 1));
    assign ptr_next = (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:  if (arb_any) next_state = ST_ISSUE;
            ST_ISSUE: next_state = ST_WAIT;
            ST_WAIT:  if (ddone || tmo) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            win      <= '0;
            win_oh   <= '0;
            cnt      <= '0;
            err_flag <= 1'b0;
            dx0      <= '0;
            dx1      <= '0;
            dy0      <= '0;
            dy1      <= '0;
            dcolor   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        win    <= arb_idx;
                        win_oh <= arb_grant;
                        dx0    <= (cx0 < cx1) ? cx0 : cx1;
                        dx1    <= (cx0 < cx1) ? cx1 : cx0;
                        dy0    <= (cy0 < cy1) ? cy0 : cy1;
                        dy1    <= (cy0 < cy1) ? cy1 : cy0;
                        dcolor <= sel_color;
                    end
                end
                ST_ISSUE: cnt <= '0;
                ST_WAIT: begin
                    // A completion in the last watchdog cycle still counts as success.
                    if (ddone || tmo) begin
                        err_flag <= ~ddone;
                        ptr      <= ptr_next;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt      = '0;
        cmd_done = '0;
        cmd_err  = 1'b0;
        dvld     = 1'b0;
        busy     = (state != ST_IDLE);
        unique case (state)
            ST_ISSUE: begin
                gnt  = win_oh;
                dvld = 1'b1;
            end
            ST_DONE: begin
                cmd_done = win_oh;
                cmd_err  = err_flag;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_draw_cmd_scheduler.sv
// Randomized self-checking bench for draw_cmd_scheduler against
// a transaction-level model of arbitration, clipping and timing.
module tb_draw_cmd_scheduler;

    localparam int N    = 4;
    localparam int XW   = 6;
    localparam int YW   = 6;
    localparam int CW   = 8;
    localparam int XMAX = 63;
    localparam int YMAX = 47;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*XW-1:0] req_x0 = '0, req_x1 = '0;
    logic [N*YW-1:0] req_y0 = '0, req_y1 = '0;
    logic [N*CW-1:0] req_color = '0;
    logic [N-1:0]    gnt, cmd_done;
    logic            cmd_err, busy, dvld;
    logic            ddone = 1'b0;
    logic [XW-1:0]   dx0, dx1;
    logic [YW-1:0]   dy0, dy1;
    logic [CW-1:0]   dcolor;

    int checks = 0;
    int errors = 0;
    int mptr = 0;
    int cur = 0;
    int cx0[N], cy0[N], cx1[N], cy1[N], ccol[N];

    draw_cmd_scheduler #(
        .N_REQ      (N),
        .TMO_CYCLES (TMO),
        .TMO_WIDTH  (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_x0    (req_x0),
        .req_x1    (req_x1),
        .req_y0    (req_y0),
        .req_y1    (req_y1),
        .req_color (req_color),
        .gnt       (gnt),
        .cmd_done  (cmd_done),
        .cmd_err   (cmd_err),
        .busy      (busy),
        .dx0       (dx0),
        .dx1       (dx1),
        .dy0       (dy0),
        .dy1       (dy1),
        .dcolor    (dcolor),
        .dvld      (dvld),
        .ddone     (ddone)
    );

    always #5 clk = ~clk;

    task automatic load(input int i, input int x0, input int y0,
                        input int x1, input int y1, input int col);
        cx0[i] = x0; cy0[i] = y0; cx1[i] = x1; cy1[i] = y1; ccol[i] = col;
        req_x0[i*XW +: XW]    = XW'(x0);
        req_x1[i*XW +: XW]    = XW'(x1);
        req_y0[i*YW +: YW]    = YW'(y0);
        req_y1[i*YW +: YW]    = YW'(y1);
        req_color[i*CW +: CW] = CW'(col);
    endtask

    task automatic load_rand(input int i);
        load(i, $urandom_range(0, 63), $urandom_range(0, 63),
             $urandom_range(0, 63), $urandom_range(0, 63),
             $urandom_range(0, 255));
    endtask

    function automatic int exp_winner();
        for (int k = 0; k < N; k++)
            if (req[(mptr + k) % N]) return (mptr + k) % N;
        return 0;
    endfunction

    function automatic int clip(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    function automatic int mn(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int mx(input int a, input int b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic all_zero();
        return (gnt === '0 && cmd_done === '0 && cmd_err === 1'b0 &&
                busy === 1'b0 && dvld === 1'b0 && dx0 === '0 &&
                dx1 === '0 && dy0 === '0 && dy1 === '0 && dcolor === '0);
    endfunction

    // Expects the model's winner to be granted lat negedges from now.
    task automatic issue_check(input int lat, input string tag);
        int w, ex0, ex1, ey0, ey1;
        logic [N-1:0] oh;
        w = exp_winner();
        oh = '0;
        oh[w] = 1'b1;
        ex0 = mn(clip(cx0[w], XMAX), clip(cx1[w], XMAX));
        ex1 = mx(clip(cx0[w], XMAX), clip(cx1[w], XMAX));
        ey0 = mn(clip(cy0[w], YMAX), clip(cy1[w], YMAX));
        ey1 = mx(clip(cy0[w], YMAX), clip(cy1[w], YMAX));
        repeat (lat) @(negedge clk);
        checks++;
        if (gnt !== oh || dvld !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_grant gnt=%b dvld=%b busy=%b required gnt=%b dvld=1 busy=1",
                     tag, gnt, dvld, busy, oh);
        end
        checks++;
        if (dx0 !== XW'(ex0) || dx1 !== XW'(ex1) || dy0 !== YW'(ey0) ||
            dy1 !== YW'(ey1) || dcolor !== CW'(ccol[w])) begin
            errors++;
            $display("FAIL %s_rect got %0d,%0d,%0d,%0d,%0h required %0d,%0d,%0d,%0d,%0h",
                     tag, dx0, dx1, dy0, dy1, dcolor, ex0, ex1, ey0, ey1, ccol[w]);
        end
        cur = w;
    endtask

    // d: negedges after the grant at which ddone is raised; d > TMO means never.
    task automatic finish_cmd(input int d, input string tag);
        int k;
        logic [N-1:0] oh;
        logic e;
        k = (d <= TMO) ? d : TMO;
        e = (d > TMO);
        for (int j = 1; j <= k; j++) begin
            @(negedge clk);
            checks++;
            if (cmd_done !== '0 || dvld !== 1'b0 || gnt !== '0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_wait cycle %0d done=%b dvld=%b gnt=%b busy=%b required 0 0 0 1",
                         tag, j, cmd_done, dvld, gnt, busy);
            end
            if (j == d) ddone = 1'b1;
        end
        @(negedge clk);
        ddone = 1'b0;
        oh = '0;
        oh[cur] = 1'b1;
        checks++;
        if (cmd_done !== oh || cmd_err !== e) begin
            errors++;
            $display("FAIL %s_done cmd_done=%b cmd_err=%b required %b %b",
                     tag, cmd_done, cmd_err, oh, e);
        end
        mptr = (cur + 1) % N;
    endtask

    task automatic post_done(input string tag);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_done !== '0 || cmd_err !== 1'b0 || dvld !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle busy=%b done=%b err=%b dvld=%b required all 0",
                     tag, busy, cmd_done, cmd_err, dvld);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (!all_zero()) begin
            errors++;
            $display("FAIL reset_hold gnt=%b done=%b busy=%b dvld=%b dx0=%0d required all 0",
                     gnt, cmd_done, busy, dvld, dx0);
        end
        rst = 1'b0;
        mptr = 0;
        @(negedge clk);
        ddone = 1'b1;
        @(negedge clk);
        ddone = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (!all_zero()) begin
                errors++;
                $display("FAIL idle_ddone gnt=%b done=%b err=%b busy=%b dvld=%b required all 0",
                         gnt, cmd_done, cmd_err, busy, dvld);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single();
        load(2, 10, 5, 3, 2, 'h1F);
        req = 4'b0100;
        issue_check(1, "single");
        checks++;
        if ({dx0, dx1, dy0, dy1, dcolor} !== {6'd3, 6'd10, 6'd2, 6'd5, 8'h1F}) begin
            errors++;
            $display("FAIL single_values got %0d %0d %0d %0d %0h required 3 10 2 5 1f",
                     dx0, dx1, dy0, dy1, dcolor);
        end
        req[2] = 1'b0;
        finish_cmd(12, "single");
        post_done("single");
    endtask

    task automatic test_clip();
        load(1, 5, 7, 63, 60, 'hA5);
        req = 4'b0010;
        issue_check(1, "clip");
        checks++;
        if ({dx0, dx1, dy0, dy1} !== {6'd5, 6'd63, 6'd7, 6'd47}) begin
            errors++;
            $display("FAIL clip_values got %0d %0d %0d %0d required 5 63 7 47",
                     dx0, dx1, dy0, dy1);
        end
        req = '0;
        finish_cmd(3, "clip");
        post_done("clip");
        load(0, 40, 55, 20, 50, 'h33);
        req = 4'b0001;
        issue_check(1, "clip2");
        checks++;
        if ({dx0, dx1, dy0, dy1} !== {6'd20, 6'd40, 6'd47, 6'd47}) begin
            errors++;
            $display("FAIL clip2_values got %0d %0d %0d %0d required 20 40 47 47",
                     dx0, dx1, dy0, dy1);
        end
        req = '0;
        finish_cmd(1, "clip2");
        post_done("clip2");
    endtask

    task automatic test_timeout();
        load_rand(3);
        req = 4'b1000;
        issue_check(1, "tmo");
        req = '0;
        finish_cmd(TMO + 4, "tmo");
        post_done("tmo");
        load_rand(0);
        req = 4'b0001;
        issue_check(1, "tmo_edge");
        req = '0;
        finish_cmd(TMO, "tmo_edge");
        post_done("tmo_edge");
    endtask

    task automatic test_fair();
        int order[5];
        int want[5] = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mptr = 0;
        for (int i = 0; i < N; i++) load_rand(i);
        req = 4'hF;
        issue_check(1, "fair");
        order[0] = cur;
        for (int n = 0; n < 5; n++) begin
            load_rand(cur);
            if (n == 4) req = '0;
            finish_cmd(5, "fair");
            if (n < 4) begin
                post_done("fair");
                issue_check(1, "fair");
                order[n+1] = cur;
            end
        end
        post_done("fair_end");
        for (int n = 0; n < 5; n++) begin
            checks++;
            if (order[n] != want[n]) begin
                errors++;
                $display("FAIL fair_order slot %0d got %0d required %0d",
                         n, order[n], want[n]);
            end
        end
    endtask

    task automatic test_rst_wait();
        load_rand(2);
        req = 4'b0100;
        issue_check(1, "rstw");
        req = '0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (!all_zero()) begin
                errors++;
                $display("FAIL rst_wait cycle %0d gnt=%b done=%b busy=%b dvld=%b dx1=%0d required all 0",
                         i, gnt, cmd_done, busy, dvld, dx1);
            end
            if (i == 1) rst = 1'b0;
            @(negedge clk);
        end
        mptr = 0;
        load_rand(1);
        load_rand(3);
        req = 4'b1010;
        issue_check(1, "rst_ptr");
        req[cur] = 1'b0;
        finish_cmd(2, "rst_ptr");
        post_done("rst_ptr");
        issue_check(1, "rst_ptr2");
        req = '0;
        finish_cmd(4, "rst_ptr2");
        post_done("rst_ptr2");
    endtask

    task automatic test_random(input int n);
        logic [N-1:0] r;
        int d;
        r = N'($urandom_range(1, 15));
        for (int i = 0; i < N; i++) if (r[i]) load_rand(i);
        req = r;
        issue_check(1, "rand");
        for (int t = 0; t < n; t++) begin
            if ($urandom_range(0, 1) == 1) load_rand(cur);
            else req[cur] = 1'b0;
            d = $urandom_range(1, TMO + 4);
            finish_cmd(d, "rand");
            r = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                if (r[i] && !req[i]) begin
                    load_rand(i);
                    req[i] = 1'b1;
                end
            end
            if (req == '0) begin
                d = $urandom_range(0, N - 1);
                load_rand(d);
                req[d] = 1'b1;
            end
            post_done("rand");
            issue_check(1, "rand");
        end
        req = '0;
        finish_cmd(3, "rand_end");
        post_done("rand_end");
    endtask

    initial begin
        test_reset();
        test_single();
        test_clip();
        test_timeout();
        test_fair();
        test_rst_wait();
        test_random(40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
